// File: rtl/fpu_shared_arb.sv
// Round-robin arbiter sharing one fixed-latency FPU among NUM_REQ requesters.
// Optional per-requester sticky flags: define FPU_ARB_STICKY_FLAGS_EN.
module fpu_shared_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned C_LAT   = 3,
  parameter int unsigned C_OP    = 32,
  parameter int unsigned C_CMD   = 4,
  parameter int unsigned C_RM    = 3,
  parameter int unsigned C_FLG   = 6
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic [NUM_REQ-1:0]         Req_SI,
  input  logic [NUM_REQ*C_OP-1:0]    Operand_a_DI,
  input  logic [NUM_REQ*C_OP-1:0]    Operand_b_DI,
  input  logic [NUM_REQ*C_CMD-1:0]   Op_SI,
  input  logic [NUM_REQ*C_RM-1:0]    RM_SI,
  output logic [NUM_REQ-1:0]         Gnt_SO,
  output logic [NUM_REQ-1:0]         Valid_SO,
  output logic [C_OP-1:0]            Result_DO,
  output logic [C_FLG-1:0]           Flags_DO,
  output logic                       FPU_En_SO,
  output logic [C_OP-1:0]            FPU_Operand_a_DO,
  output logic [C_OP-1:0]            FPU_Operand_b_DO,
  output logic [C_CMD-1:0]           FPU_Op_SO,
  output logic [C_RM-1:0]            FPU_RM_SO,
  input  logic [C_OP-1:0]            FPU_Result_DI,
  input  logic [C_FLG-1:0]           FPU_Flags_DI,
  input  logic                       Halt_SI,
`ifdef FPU_ARB_STICKY_FLAGS_EN
  input  logic [NUM_REQ-1:0]         Flags_clr_SI,
  output logic [NUM_REQ*C_FLG-1:0]   Sticky_DO,
`endif
  output logic                       Halted_SO
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [C_LAT-1:0] pv_q;
  logic [IDW-1:0]   pid_q [C_LAT];
  logic [IDW-1:0]   gnt_id, sel_id, idx;
  logic             found, issue_ok, pipe_empty;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && Req_SI[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign issue_ok  = (state_q == RUN) && !Halt_SI;
  assign FPU_En_SO = issue_ok && found;
  assign sel_id    = FPU_En_SO ? gnt_id : '0;

  always_comb begin
    Gnt_SO = '0;
    if (FPU_En_SO) Gnt_SO[gnt_id] = 1'b1;
  end

  assign FPU_Operand_a_DO = Operand_a_DI[32'(sel_id)*C_OP +: C_OP];
  assign FPU_Operand_b_DO = Operand_b_DI[32'(sel_id)*C_OP +: C_OP];
  assign FPU_Op_SO        = Op_SI[32'(sel_id)*C_CMD +: C_CMD];
  assign FPU_RM_SO        = RM_SI[32'(sel_id)*C_RM +: C_RM];

  // Requester-ID shadow of the FPU pipeline; never stalls.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      pv_q <= '0;
      for (int i = 0; i < int'(C_LAT); i++) pid_q[i] <= '0;
    end else begin
      pv_q[0]  <= FPU_En_SO;
      pid_q[0] <= gnt_id;
      for (int i = 1; i < int'(C_LAT); i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  assign pipe_empty = ~|pv_q;

  always_comb begin
    Valid_SO = '0;
    if (pv_q[C_LAT-1]) Valid_SO[pid_q[C_LAT-1]] = 1'b1;
  end

  assign Result_DO = FPU_Result_DI;
  assign Flags_DO  = FPU_Flags_DI;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      ptr_q <= '0;
    end else if (FPU_En_SO) begin
      if (32'(gnt_id) == NUM_REQ - 1) ptr_q <= '0;
      else ptr_q <= gnt_id + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == RUN:    if (Halt_SI) state_d = DRAIN;
      state_q == DRAIN: begin
        if (!Halt_SI) state_d = RUN;
        else if (pipe_empty) state_d = HALTED;
      end
      state_q == HALTED: if (!Halt_SI) state_d = RUN;
      default:           state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) state_q <= RUN;
    else state_q <= state_d;
  end

  assign Halted_SO = (state_q == HALTED);

`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic [NUM_REQ*C_FLG-1:0] sticky_q;

  // A return in the same cycle as a clear survives the clear.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        sticky_q[i*C_FLG +: C_FLG] <=
          (Flags_clr_SI[i] ? '0 : sticky_q[i*C_FLG +: C_FLG]) |
          (Valid_SO[i] ? FPU_Flags_DI : '0);
      end
    end
  end

  assign Sticky_DO = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_shared_arb.sv
// Bench for fpu_shared_arb: directed table, hand sequences and a
// randomized run against a cycle-indexed reference model.
module tb_fpu_shared_arb;

  localparam int N    = 2;
  localparam int L    = 3;
  localparam int NCYC = 3000;

  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_HALTED = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*32-1:0] opa, opb;
  logic [N*4-1:0]  op;
  logic [N*3-1:0]  rm;
  logic [N-1:0]  gnt, valid;
  logic [31:0]   res, fa, fb, fres;
  logic [5:0]    flg, fflg;
  logic          en, halt, halted;
  logic [3:0]    fop;
  logic [2:0]    frm;
`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic [N-1:0]   clr;
  logic [N*6-1:0] sticky;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fpu_shared_arb #(.NUM_REQ(N), .C_LAT(L)) dut (
    .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req),
    .Operand_a_DI(opa), .Operand_b_DI(opb),
    .Op_SI(op), .RM_SI(rm),
    .Gnt_SO(gnt), .Valid_SO(valid),
    .Result_DO(res), .Flags_DO(flg),
    .FPU_En_SO(en),
    .FPU_Operand_a_DO(fa), .FPU_Operand_b_DO(fb),
    .FPU_Op_SO(fop), .FPU_RM_SO(frm),
    .FPU_Result_DI(fres), .FPU_Flags_DI(fflg),
    .Halt_SI(halt),
`ifdef FPU_ARB_STICKY_FLAGS_EN
    .Flags_clr_SI(clr), .Sticky_DO(sticky),
`endif
    .Halted_SO(halted)
  );

  typedef struct {
    logic [N-1:0] req;
    logic         halt;
    logic [N-1:0] gnt;
    logic [N-1:0] valid;
    logic         halted;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic new_ops(input int i);
    opa[i*32 +: 32] = $urandom;
    opb[i*32 +: 32] = $urandom;
    op[i*4 +: 4]    = 4'($urandom);
    rm[i*3 +: 3]    = 3'($urandom);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic h,
                       input logic rs);
    @(posedge clk);
    #1;
    req  = r;
    halt = h;
    rst  = rs;
    fres = $urandom;
    fflg = 6'($urandom);
    #4;
  endtask

  task automatic v(input logic [N-1:0] r, input logic h,
                   input logic [N-1:0] g, input logic [N-1:0] vl,
                   input logic hd);
    vec_t e;
    e.req = r; e.halt = h; e.gnt = g; e.valid = vl; e.halted = hd;
    tbl.push_back(e);
  endtask

  task automatic chk_issue(input int gi, input string tag);
    int s;
    s = (gi < 0) ? 0 : gi;
    chk({tag, "_en"}, 64'(en), 64'(gi >= 0));
    chk({tag, "_opa"}, 64'(fa), 64'(opa[s*32 +: 32]));
    chk({tag, "_opb"}, 64'(fb), 64'(opb[s*32 +: 32]));
    chk({tag, "_op"}, 64'(fop), 64'(op[s*4 +: 4]));
    chk({tag, "_rm"}, 64'(frm), 64'(rm[s*3 +: 3]));
  endtask

  // Reference model state: absolute-cycle return schedule.
  int sched [NCYC + L + 4];
  int ptr, mode, last_g, eg;
  logic busy;

  initial begin
    rst = 1'b1; req = '0; halt = 1'b0;
    fres = '0; fflg = '0;
`ifdef FPU_ARB_STICKY_FLAGS_EN
    clr = '0;
`endif
    for (int i = 0; i < N; i++) new_ops(i);

    v(2'b00, 0, 2'b00, 2'b00, 0);
    v(2'b11, 0, 2'b01, 2'b00, 0);
    v(2'b11, 0, 2'b10, 2'b00, 0);
    v(2'b11, 0, 2'b01, 2'b00, 0);
    v(2'b11, 0, 2'b10, 2'b01, 0);
    v(2'b00, 0, 2'b00, 2'b10, 0);
    v(2'b00, 0, 2'b00, 2'b01, 0);
    v(2'b00, 0, 2'b00, 2'b10, 0);
    v(2'b01, 0, 2'b01, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b01, 0);
    v(2'b11, 0, 2'b10, 2'b00, 0);
    v(2'b01, 0, 2'b01, 2'b00, 0);
    v(2'b01, 0, 2'b01, 2'b00, 0);
    v(2'b01, 0, 2'b01, 2'b10, 0);
    v(2'b00, 0, 2'b00, 2'b01, 0);
    v(2'b00, 0, 2'b00, 2'b01, 0);
    v(2'b00, 0, 2'b00, 2'b01, 0);
    v(2'b00, 0, 2'b00, 2'b00, 0);
    v(2'b11, 0, 2'b10, 2'b00, 0);
    v(2'b11, 0, 2'b01, 2'b00, 0);
    v(2'b11, 1, 2'b00, 2'b00, 0);
    v(2'b11, 1, 2'b00, 2'b10, 0);
    v(2'b11, 1, 2'b00, 2'b01, 0);
    v(2'b11, 1, 2'b00, 2'b00, 0);
    v(2'b11, 1, 2'b00, 2'b00, 1);
    v(2'b11, 0, 2'b00, 2'b00, 1);
    v(2'b11, 0, 2'b10, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b10, 0);
    v(2'b00, 1, 2'b00, 2'b00, 0);
    v(2'b00, 1, 2'b00, 2'b00, 0);
    v(2'b00, 1, 2'b00, 2'b00, 1);
    v(2'b00, 0, 2'b00, 2'b00, 1);
    v(2'b01, 0, 2'b01, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b00, 0);
    v(2'b00, 0, 2'b00, 2'b01, 0);

    repeat (3) @(posedge clk);
    foreach (tbl[k]) begin
      drive(tbl[k].req, tbl[k].halt, 1'b0);
      chk($sformatf("t%0d_gnt", k), 64'(gnt), 64'(tbl[k].gnt));
      chk($sformatf("t%0d_valid", k), 64'(valid), 64'(tbl[k].valid));
      chk($sformatf("t%0d_halted", k), 64'(halted), 64'(tbl[k].halted));
      chk_issue(tbl[k].gnt[1] ? 1 : (tbl[k].gnt[0] ? 0 : -1), "t_iss");
      if (tbl[k].valid != 0) begin
        chk("t_res", 64'(res), 64'(fres));
        chk("t_flg", 64'(flg), 64'(fflg));
      end
    end

    // Reset one cycle after an issue discards the in-flight op.
    drive(2'b01, 0, 0);
    chk("rst_issue", 64'(gnt), 64'(2'b01));
    drive(2'b00, 0, 1);
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 0, 0);
      chk("rst_novalid", 64'(valid), 64'(2'b00));
      chk("rst_halted", 64'(halted), 64'(1'b0));
    end
    drive(2'b11, 0, 0);
    chk("rst_ptr0", 64'(gnt), 64'(2'b01));

`ifdef FPU_ARB_STICKY_FLAGS_EN
    drive(2'b00, 0, 1);
    drive(2'b01, 0, 0);
    drive(2'b01, 0, 0);
    drive(2'b00, 0, 0);
    drive(2'b00, 0, 0); fflg = 6'h01;
    drive(2'b00, 0, 0); fflg = 6'h08;
    drive(2'b01, 0, 0);
    chk("sticky0_acc", 64'(sticky[5:0]), 64'(6'h09));
    chk("sticky1_idle", 64'(sticky[11:6]), 64'(6'h00));
    drive(2'b00, 0, 0);
    drive(2'b00, 0, 0);
    drive(2'b00, 0, 0); fflg = 6'h10; clr = 2'b01;
    drive(2'b00, 0, 0); clr = 2'b00;
    chk("sticky0_clrset", 64'(sticky[5:0]), 64'(6'h10));
`endif

    drive(2'b00, 0, 1);
    for (int j = 0; j < NCYC + L + 4; j++) sched[j] = -1;
    ptr = 0; mode = M_RUN; last_g = -1;
    req = '0; halt = 1'b0;

    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (i == last_g) begin
          req[i] = 1'($urandom_range(0, 1));
          if (req[i]) new_ops(i);
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            new_ops(i);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 39) == 0) halt = ~halt;
      rst  = ($urandom_range(0, 249) == 0);
      fres = $urandom;
      fflg = 6'($urandom);
      #4;
      if (rst) begin
        for (int j = t; j < NCYC + L + 4; j++) sched[j] = -1;
        ptr = 0; mode = M_RUN; last_g = -1;
        continue;
      end
      eg = -1;
      if (mode == M_RUN && !halt) begin
        for (int k = 0; k < N; k++) begin
          if (eg < 0 && req[(ptr + k) % N]) eg = (ptr + k) % N;
        end
      end
      chk("r_gnt", 64'(gnt), (eg < 0) ? 64'd0 : (64'd1 << eg));
      chk_issue(eg, "r_iss");
      chk("r_valid", 64'(valid),
          (sched[t] < 0) ? 64'd0 : (64'd1 << sched[t]));
      if (sched[t] >= 0) begin
        chk("r_res", 64'(res), 64'(fres));
        chk("r_flg", 64'(flg), 64'(fflg));
      end
      chk("r_halted", 64'(halted), 64'(mode == M_HALTED));
      busy = 1'b0;
      for (int j = t; j < t + L; j++) if (sched[j] >= 0) busy = 1'b1;
      if (eg >= 0) begin
        sched[t + L] = eg;
        ptr = (eg + 1) % N;
      end
      case (mode)
        M_RUN:   if (halt) mode = M_DRAIN;
        M_DRAIN: if (!halt) mode = M_RUN;
                 else if (!busy) mode = M_HALTED;
        default: if (!halt) mode = M_RUN;
      endcase
      last_g = eg;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
